// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: pipelined signed Baugh-Wooley multiplier with exact,
// column-truncated and bias-compensated modes behind a valid/ready stream.
module approx_mul_pipe #(
  parameter int W      = 8,
  parameter int TRUNC  = W - 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_mode,
  input  logic [2*W-1:0]   cfg_bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic [1:0]       out_mode,
  output logic [31:0]      out_cnt
);

  localparam int PW = 2 * W;

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    mode;
    logic [PW-1:0] bias;
  } op_t;

  // Baugh-Wooley term sum; terms in columns below 'drop' are skipped,
  // the two correction constants are always added.
  function automatic logic [PW-1:0] bw_sum(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input int           drop);
    logic [PW-1:0] acc;
    logic [PW-1:0] one;
    logic          t;
    one = {{(PW-1){1'b0}}, 1'b1};
    acc = (one << W) + (one << (PW - 1));
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        if ((i == W - 1) == (j == W - 1)) begin
          t = a[i] & b[j];
        end else begin
          t = ~(a[i] & b[j]);
        end
        if (t && ((i + j) >= drop)) begin
          acc = acc + (one << (i + j));
        end else begin
          acc = acc;
        end
      end
    end
    return acc;
  endfunction

  function automatic logic [PW-1:0] clear_low(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    r = v;
    for (int k = 0; k < TRUNC; k++) begin
      r[k] = 1'b0;
    end
    return r;
  endfunction

  logic [1:0]        cfg_mode_q, cfg_mode_d;
  logic [PW-1:0]     cfg_bias_q, cfg_bias_d;
  logic [STAGES-1:0] vld_q, vld_d, en_s;
  logic [PW-1:0]     p_q, p_d;
  logic [1:0]        omode_q, omode_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [PW-1:0]     exact_s, trunc_s, res_s;
  op_t               in_op_s;
  op_t               fin_op_s;

  // Mode 3 is folded to exact at write time so it never travels downstream.
  always_comb begin
    if (cfg_we) begin
      cfg_mode_d = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
      cfg_bias_d = cfg_bias;
    end else begin
      cfg_mode_d = cfg_mode_q;
      cfg_bias_d = cfg_bias_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_mode_q <= 2'd1;
      cfg_bias_q <= '0;
    end else begin
      cfg_mode_q <= cfg_mode_d;
      cfg_bias_q <= cfg_bias_d;
    end
  end

  assign in_op_s = '{a: in_a, b: in_b, mode: cfg_mode_q, bias: cfg_bias_q};

  // A stage may load when empty or when its content leaves this cycle.
  always_comb begin
    en_s = '0;
    en_s[STAGES-1] = ~vld_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      en_s[k] = ~vld_q[k] | en_s[k+1];
    end
  end

  assign in_ready = en_s[0] & ~rst;

  always_comb begin
    vld_d = vld_q;
    if (en_s[0]) begin
      vld_d[0] = in_valid;
    end else begin
      vld_d[0] = vld_q[0];
    end
    for (int k = 1; k < STAGES; k++) begin
      if (en_s[k]) begin
        vld_d[k] = vld_q[k-1];
      end else begin
        vld_d[k] = vld_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  if (STAGES > 1) begin : g_pipe
    op_t [STAGES-2:0] op_q, op_d;

    always_comb begin
      op_d = op_q;
      if (en_s[0]) begin
        op_d[0] = in_op_s;
      end else begin
        op_d[0] = op_q[0];
      end
      for (int k = 1; k < STAGES - 1; k++) begin
        if (en_s[k]) begin
          op_d[k] = op_q[k-1];
        end else begin
          op_d[k] = op_q[k];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        op_q <= '0;
      end else begin
        op_q <= op_d;
      end
    end

    assign fin_op_s = op_q[STAGES-2];
  end else begin : g_direct
    assign fin_op_s = in_op_s;
  end

  // Final stage: full sum, truncation and bias add all resolve here.
  always_comb begin
    exact_s = bw_sum(fin_op_s.a, fin_op_s.b, 32'sd0);
    trunc_s = clear_low(bw_sum(fin_op_s.a, fin_op_s.b, TRUNC));
    case (fin_op_s.mode)
      2'd1:    res_s = trunc_s;
      2'd2:    res_s = trunc_s + fin_op_s.bias;
      default: res_s = exact_s;
    endcase
    if (en_s[STAGES-1] && vld_d[STAGES-1]) begin
      p_d     = res_s;
      omode_d = fin_op_s.mode;
    end else begin
      p_d     = p_q;
      omode_d = omode_q;
    end
  end

  always_comb begin
    if (vld_q[STAGES-1] && out_ready) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= '0;
      omode_q <= 2'd0;
      cnt_q   <= 32'd0;
    end else begin
      p_q     <= p_d;
      omode_q <= omode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_p     = p_q;
  assign out_mode  = omode_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe: directed table, config-latching
// sequence, stalled random stream, mid-flight reset and an exhaustive sweep.
module tb_approx_mul_pipe;
  localparam int W      = 8;
  localparam int TRUNC  = 6;
  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_ready1;
  logic [7:0]  in_a, in_b;
  logic        cfg_we;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_bias;
  logic        out_valid, out_valid1, out_ready;
  logic [15:0] out_p, out_p1;
  logic [1:0]  out_mode, out_mode1;
  logic [31:0] out_cnt, out_cnt1;
  logic        cfg_we1 = 1'b0;
  logic [1:0]  cfg_mode1 = 2'd0;
  logic [15:0] cfg_bias1 = 16'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_mul_pipe #(.W(W), .TRUNC(TRUNC), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cfg_bias(cfg_bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_mode(out_mode), .out_cnt(out_cnt)
  );

  // Second instance with no truncation: mode 1 (its reset mode) must be exact.
  approx_mul_pipe #(.W(W), .TRUNC(0), .STAGES(STAGES)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .cfg_we(cfg_we1), .cfg_mode(cfg_mode1),
    .cfg_bias(cfg_bias1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_p(out_p1), .out_mode(out_mode1), .out_cnt(out_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden model: exact signed product minus the positive partial products
  // that sit in the dropped columns (for W=8, TRUNC=6 only a_i*b_j, i,j<7).
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] mode, input logic [15:0] bias);
    logic [15:0] ex, dropped, tr;
    ex = 16'($signed(a)) * 16'($signed(b));
    dropped = 16'd0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        if ((i + j) < TRUNC && a[i] && b[j]) dropped = dropped + (16'd1 << (i + j));
    tr = (ex - dropped) & 16'hFFC0;
    case (mode)
      2'd1:    return tr;
      2'd2:    return tr + bias;
      default: return ex;
    endcase
  endfunction

  typedef struct {
    logic        do_cfg;
    logic [1:0]  mode;
    logic [15:0] bias;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    if (v.do_cfg) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_mode = v.mode; cfg_bias = v.bias;
    end
    @(negedge clk);
    cfg_we = 1'b0; in_a = v.a; in_b = v.b; in_valid = 1'b1;
    #1 check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(STAGES));
    check($sformatf("vec%0d_p", idx), 32'(out_p), 32'(v.exp_p));
    check($sformatf("vec%0d_mode", idx), 32'(out_mode), 32'(v.exp_mode));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] rp[2];
    logic [1:0]  rm[2];
    logic [17:0] exp_q[$];
    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] e;
    logic [1:0]  model_mode;
    logic [15:0] model_bias, prev_p;
    logic [1:0]  prev_m;
    logic        stalled_prev;
    int got, cyc, sent, recv, acc, stale, bad0, bad1, got0, got1;

    rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
    cfg_we = 1'b0; cfg_mode = 2'd0; cfg_bias = 16'd0; out_ready = 1'b1;

    vecs[0]  = '{1'b1, 2'd0, 16'h0000, 8'h80, 8'h80, 16'h4000, 2'd0};
    vecs[1]  = '{1'b1, 2'd0, 16'h0000, 8'h7F, 8'h7F, 16'h3F01, 2'd0};
    vecs[2]  = '{1'b1, 2'd0, 16'h0000, 8'hFD, 8'h05, 16'hFFF1, 2'd0};
    vecs[3]  = '{1'b1, 2'd1, 16'h0000, 8'h7F, 8'h7F, 16'h3DC0, 2'd1};
    vecs[4]  = '{1'b1, 2'd1, 16'h0000, 8'h01, 8'h01, 16'h0000, 2'd1};
    vecs[5]  = '{1'b1, 2'd1, 16'h0000, 8'h80, 8'h80, 16'h4000, 2'd1};
    vecs[6]  = '{1'b1, 2'd1, 16'h0000, 8'hFF, 8'hFF, 16'hFEC0, 2'd1};
    vecs[7]  = '{1'b1, 2'd2, 16'h00A0, 8'h7F, 8'h7F, 16'h3E60, 2'd2};
    vecs[8]  = '{1'b1, 2'd2, 16'hFFFF, 8'h01, 8'h01, 16'hFFFF, 2'd2};
    vecs[9]  = '{1'b1, 2'd3, 16'h0000, 8'h7F, 8'h80, 16'hC080, 2'd0};
    vecs[10] = '{1'b0, 2'd1, 16'h0000, 8'h7F, 8'h7F, 16'h3DC0, 2'd1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_p", 32'(out_p), 32'd0);
    check("post_rst_out_mode", 32'(out_mode), 32'd0);
    check("post_rst_out_cnt", 32'(out_cnt), 32'd0);

    // Directed table (last entry relies on the current mode, checked later)
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Config write in the same cycle as an accept only affects later pairs
    @(negedge clk);
    cfg_we = 1'b1; cfg_mode = 2'd2; cfg_bias = 16'h00A0;
    @(negedge clk);
    in_a = 8'h7F; in_b = 8'h7F; in_valid = 1'b1; cfg_mode = 2'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    got = 0; cyc = 0;
    while (got < 2 && cyc < 10) begin
      if (out_valid) begin
        rp[got] = out_p; rm[got] = out_mode; got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("samecyc_count", 32'(got), 32'd2);
    if (got == 2) begin
      check("samecyc_p0", 32'(rp[0]), 32'h3E60);
      check("samecyc_m0", 32'(rm[0]), 32'd2);
      check("samecyc_p1", 32'(rp[1]), 32'h3F01);
      check("samecyc_m1", 32'(rm[1]), 32'd0);
    end

    // Random stream with toggling backpressure and random config writes
    do_reset();
    model_mode = 2'd1; model_bias = 16'd0;
    sent = 0; recv = 0; cyc = 0; stalled_prev = 1'b0;
    prev_p = 16'd0; prev_m = 2'd0;
    while ((sent < 20 || recv < 20) && cyc < 500) begin
      @(negedge clk);
      if (stalled_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_p", 32'(out_p), 32'(prev_p));
        check("stall_mode", 32'(out_mode), 32'(prev_m));
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_bias = 16'($urandom);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({model_mode, model(in_a, in_b, model_mode, model_bias)});
        sent++;
      end
      if (cfg_we) begin
        model_mode = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
        model_bias = cfg_bias;
      end
      if (out_valid && out_ready) begin
        check("stream_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("stream%0d_p", recv), 32'(out_p), 32'(e[15:0]));
          check($sformatf("stream%0d_mode", recv), 32'(out_mode), 32'(e[17:16]));
        end
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_p = out_p; prev_m = out_mode;
      cyc++;
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    check("stream_recv", 32'(recv), 32'd20);
    check("stream_leftover", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("stream_out_cnt", out_cnt, 32'd20);

    // Fill under backpressure, then reset with items in flight
    @(negedge clk);
    cfg_we = 1'b1; cfg_mode = 2'd0; cfg_bias = 16'h1234;
    @(negedge clk);
    cfg_we = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd7;
    acc = 0;
    for (int c = 0; c < STAGES + 3; c++) begin
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    check("fill_accepts", 32'(acc), 32'(STAGES));
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_cnt", out_cnt, 32'd0);
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    run_vec(vecs[10], 10);

    // Exhaustive sweep: dut in mode 0, dut1 (TRUNC=0) in its reset mode 1
    do_reset();
    @(negedge clk);
    cfg_we = 1'b1; cfg_mode = 2'd0; cfg_bias = 16'd0;
    bad0 = 0; bad1 = 0; got0 = 0; got1 = 0;
    for (int n = 0; n < 65536 + 10; n++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (n < 65536) begin
        in_valid = 1'b1; in_a = n[15:8]; in_b = n[7:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready)  q0.push_back({2'd0, model(in_a, in_b, 2'd0, 16'd0)});
      if (in_valid && in_ready1) q1.push_back({2'd1, model(in_a, in_b, 2'd0, 16'd0)});
      if (out_valid) begin
        got0++;
        if (q0.size() > 0) begin
          e = q0.pop_front();
          if (out_p !== e[15:0] || out_mode !== e[17:16]) bad0++;
        end else bad0++;
      end
      if (out_valid1) begin
        got1++;
        if (q1.size() > 0) begin
          e = q1.pop_front();
          if (out_p1 !== e[15:0] || out_mode1 !== e[17:16]) bad1++;
        end else bad1++;
      end
    end
    check("sweep_mode0_errors", 32'(bad0), 32'd0);
    check("sweep_mode0_count", 32'(got0), 32'd65536);
    check("sweep_trunc0_errors", 32'(bad1), 32'd0);
    check("sweep_trunc0_count", 32'(got1), 32'd65536);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
